// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive equal enabled samples of w. Samples are counted across en=0 gaps.
// Optional detection-event counter enabled by defining RUN_DET_COUNT_EN.
module run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
`ifdef RUN_DET_COUNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] event_cnt,
`endif
    output logic             detect,
    output logic             detect_val,
    output logic             det_pulse,
    output logic [4:0]       run_cnt,
    output logic [2:0]       state
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RUN0 = 3'd1;
    localparam logic [2:0] RUN1 = 3'd2;
    localparam logic [2:0] DET0 = 3'd3;
    localparam logic [2:0] DET1 = 3'd4;
    localparam logic [4:0] RL   = 5'(RUN_LEN);

    logic [2:0] nxt_state;
    logic [4:0] nxt_cnt;
    logic       run_val;
    logic       in_det;
    logic       nxt_det;
    logic       entering;

    assign run_val  = (state == RUN1) || (state == DET1);
    assign in_det   = (state == DET0) || (state == DET1);
    assign nxt_det  = (nxt_state == DET0) || (nxt_state == DET1);
    // Only RUN -> DET counts as an entry; DET never jumps to the opposite DET.
    assign entering = nxt_det && !in_det;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = run_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    nxt_state = w ? RUN1 : RUN0;
                    nxt_cnt   = 5'd1;
                end
            end
            RUN0, RUN1, DET0, DET1: begin
                if (en) begin
                    if (w != run_val) begin
                        nxt_state = w ? RUN1 : RUN0;
                        nxt_cnt   = 5'd1;
                    end else if (in_det) begin
                        nxt_cnt   = RL;
                    end else begin
                        nxt_cnt   = run_cnt + 5'd1;
                        if (nxt_cnt == RL)
                            nxt_state = w ? DET1 : DET0;
                    end
                end
            end
            default: begin
                // Unused codes recover to IDLE whether or not a sample is enabled.
                nxt_state = IDLE;
                nxt_cnt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            run_cnt   <= 5'd0;
            det_pulse <= 1'b0;
        end else begin
            state     <= nxt_state;
            run_cnt   <= nxt_cnt;
            det_pulse <= entering;
        end
    end

    assign detect     = in_det;
    assign detect_val = (state == DET1);

`ifdef RUN_DET_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clr)
            event_cnt <= '0;
        else if (entering && (event_cnt != {CNT_W{1'b1}}))
            event_cnt <= event_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_run_detector.sv
// Table-driven bench for run_detector (RUN_LEN=4, CNT_W=2); event_cnt checked when RUN_DET_COUNT_EN is defined.
module tb_run_detector;

    localparam logic [2:0] I0 = 3'd0;
    localparam logic [2:0] R0 = 3'd1;
    localparam logic [2:0] R1 = 3'd2;
    localparam logic [2:0] D0 = 3'd3;
    localparam logic [2:0] D1 = 3'd4;

    logic       clk = 1'b0;
    logic       reset, en, w, cnt_clr;
    logic       detect, detect_val, det_pulse;
    logic [4:0] run_cnt;
    logic [2:0] state;
    logic [1:0] event_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_detector #(.RUN_LEN(4), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .w          (w),
`ifdef RUN_DET_COUNT_EN
        .cnt_clr    (cnt_clr),
        .event_cnt  (event_cnt),
`endif
        .detect     (detect),
        .detect_val (detect_val),
        .det_pulse  (det_pulse),
        .run_cnt    (run_cnt),
        .state      (state)
    );

`ifndef RUN_DET_COUNT_EN
    assign event_cnt = 2'd0;
`endif

    typedef struct {
        logic       rst, en, w, clr;
        logic [2:0] st;
        logic [4:0] cnt;
        logic       det, dv, dp;
        logic [1:0] ev;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic e, input logic wv, input logic clr,
                       input logic [2:0] st, input logic [4:0] cnt,
                       input logic det, input logic dv, input logic dp, input logic [1:0] ev);
        vec_t v;
        v.rst = rst; v.en = e; v.w = wv; v.clr = clr;
        v.st = st; v.cnt = cnt; v.det = det; v.dv = dv; v.dp = dp; v.ev = ev;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs, clock them in, then sample just after the edge.
    task automatic apply(input logic rst, input logic e, input logic wv, input logic clr);
        reset = rst; en = e; w = wv; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input int idx, input logic [2:0] st, input logic [4:0] cnt,
                            input logic det, input logic dv, input logic dp);
        chk("state", idx, int'(state), int'(st));
        chk("run_cnt", idx, int'(run_cnt), int'(cnt));
        chk("detect", idx, int'(detect), int'(det));
        chk("detect_val", idx, int'(detect_val), int'(dv));
        chk("det_pulse", idx, int'(det_pulse), int'(dp));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; w = 1'b0; cnt_clr = 1'b0;

        add(1,0,0,0, I0,0,0,0,0, 0);
        // Continuous zeros from reset: detect after the 4th edge, then hold.
        for (int i = 1; i <= 3; i++) add(0,1,0,0, R0,5'(i),0,0,0, 0);
        add(0,1,0,0, D0,4,1,0,1, 1);
        add(0,1,0,0, D0,4,1,0,0, 1);
        // Reset wins over en; then 1,1,1,0,1,1,1,1.
        add(1,1,1,0, I0,0,0,0,0, 0);
        for (int i = 1; i <= 3; i++) add(0,1,1,0, R1,5'(i),0,0,0, 0);
        add(0,1,0,0, R0,1,0,0,0, 0);
        for (int i = 1; i <= 3; i++) add(0,1,1,0, R1,5'(i),0,0,0, 0);
        add(0,1,1,0, D1,4,1,1,1, 1);
        // DET1 broken by a 0, then four zeros reach DET0 with one pulse.
        for (int i = 1; i <= 3; i++) add(0,1,0,0, R0,5'(i),0,0,0, 1);
        add(0,1,0,0, D0,4,1,0,1, 2);
        add(0,0,1,0, D0,4,1,0,0, 2);
        add(0,1,0,0, D0,4,1,0,0, 2);
        // Reset in DET0, and reset held with en=1, w=0.
        add(1,1,0,0, I0,0,0,0,0, 0);
        add(1,1,0,0, I0,0,0,0,0, 0);
        // Gap of five disabled cycles inside a run.
        add(0,1,0,0, R0,1,0,0,0, 0);
        add(0,1,0,0, R0,2,0,0,0, 0);
        for (int k = 0; k < 5; k++) add(0,0,logic'(k % 2),0, R0,2,0,0,0, 0);
        add(0,1,0,0, R0,3,0,0,0, 0);
        add(0,1,0,0, D0,4,1,0,1, 1);
        // Reset mid-run discards the run.
        add(0,1,1,0, R1,1,0,0,0, 1);
        add(0,1,1,0, R1,2,0,0,0, 1);
        add(1,1,1,0, I0,0,0,0,0, 0);
        add(0,1,1,0, R1,1,0,0,0, 0);
        // Five alternating detections: event_cnt 1,2,3,3,3 with CNT_W=2.
        add(1,0,0,0, I0,0,0,0,0, 0);
        for (int j = 0; j < 5; j++) begin
            logic wv;
            logic [1:0] evb, eva;
            wv  = logic'(j % 2);
            evb = (j > 3) ? 2'd3 : 2'(j);
            eva = (j + 1 > 3) ? 2'd3 : 2'(j + 1);
            for (int i = 1; i <= 3; i++) add(0,1,wv,0, wv ? R1 : R0,5'(i),0,0,0, evb);
            add(0,1,wv,0, wv ? D1 : D0,4,1,wv,1, eva);
        end
        // cnt_clr coincident with a detection wins over the increment.
        for (int i = 1; i <= 3; i++) add(0,1,1,0, R1,5'(i),0,0,0, 3);
        add(0,1,1,1, D1,4,1,1,1, 0);
        add(0,1,1,0, D1,4,1,1,0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].w, tbl[i].clr);
            chk_outs(i, tbl[i].st, tbl[i].cnt, tbl[i].det, tbl[i].dv, tbl[i].dp);
`ifdef RUN_DET_COUNT_EN
            chk("event_cnt", i, int'(event_cnt), int'(tbl[i].ev));
`endif
        end

        // Hand sequence: noisy w during en=0 gaps, in RUN and in DET.
        apply(1,0,0,0);
        for (int i = 1; i <= 3; i++) apply(0,1,1,0);
        chk_outs(1000, R1, 3, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            apply(0,0,logic'($urandom_range(0,1)),0);
            chk_outs(1001 + k, R1, 3, 0, 0, 0);
        end
        apply(0,1,1,0);
        chk_outs(1010, D1, 4, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            apply(0,0,logic'(k % 2),0);
            chk_outs(1011 + k, D1, 4, 1, 1, 0);
        end
        apply(0,1,0,0);
        chk_outs(1020, R0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
